demux_1x2_buf: RTL and testbench

//   Buffered 1-to-2 demultiplexer: routes one 32-bit word stream to one of two

---
 rtl/demux_1x2_buf_if.sv | 31 +++
 rtl/demux_1x2_buf.sv | 116 +++++++++++
 tb/tb_demux_1x2_buf.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/demux_1x2_buf_if.sv
// Handshake bundle for the buffered 1-to-2 demux: one source side and two consumer sides.
// The master side drives the source and the consumer readies; the slave side is the demux.
interface demux_1x2_buf_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] I;
  logic             s;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] Y0;
  logic             valid0;
  logic             ready0;
  logic [WIDTH-1:0] Y1;
  logic             valid1;
  logic             ready1;
  logic [CW-1:0]    cnt0;
  logic [CW-1:0]    cnt1;

  modport master (
    output I, s, in_valid, ready0, ready1,
    input  in_ready, Y0, valid0, Y1, valid1, cnt0, cnt1
  );

  modport slave (
    input  I, s, in_valid, ready0, ready1,
    output in_ready, Y0, valid0, Y1, valid1, cnt0, cnt1
  );
endinterface

// File: rtl/demux_1x2_buf.sv
// Buffered 1-to-2 demux: steers a word stream into one of two per-destination FIFOs,
// each drained by its own valid/ready consumer.

module demux_1x2_buf_lane #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop_req,
  output logic [WIDTH-1:0] rdata,
  output logic             vld,
  output logic             full,
  output logic [CW-1:0]    cnt
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [PW-1:0]               wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]               rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic                        do_push, do_pop;

  assign vld  = (cnt_q != '0);
  assign full = (cnt_q == CW'(DEPTH));
  assign cnt  = cnt_q;
  // Head is forced to zero when empty so a consumer never sees a stale word.
  assign rdata = vld ? mem_q[rd_ptr_q] : '0;

  // Full refuses a push even when the same edge pops: keeps in_ready off the pop path.
  assign do_push = push & ~full;
  assign do_pop  = pop_req & vld;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset; validity is carried entirely by cnt_q.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule

module demux_1x2_buf #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  demux_1x2_buf_if.slave   bus
);
  localparam int NUM_LANES = 2;
  localparam int CW        = $clog2(DEPTH) + 1;

  logic [NUM_LANES-1:0]            sel, push, pop_req, vld, full;
  logic [NUM_LANES-1:0][WIDTH-1:0] dout;
  logic [NUM_LANES-1:0][CW-1:0]    cnt;

  assign sel          = {bus.s, ~bus.s};
  assign bus.in_ready = ~full[bus.s];
  assign push         = {NUM_LANES{bus.in_valid & bus.in_ready}} & sel;
  assign pop_req      = {bus.ready1, bus.ready0};

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    demux_1x2_buf_lane #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .CW    (CW)
    ) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (push[k]),
      .wdata   (bus.I),
      .pop_req (pop_req[k]),
      .rdata   (dout[k]),
      .vld     (vld[k]),
      .full    (full[k]),
      .cnt     (cnt[k])
    );
  end

  assign bus.Y0     = dout[0];
  assign bus.valid0 = vld[0];
  assign bus.cnt0   = cnt[0];
  assign bus.Y1     = dout[1];
  assign bus.valid1 = vld[1];
  assign bus.cnt1   = cnt[1];
endmodule

// File: tb/tb_demux_1x2_buf.sv
// Directed bench for demux_1x2_buf: routing, backpressure, push/pop overlap,
// full-FIFO bubble, async reset mid-stream and a randomized-ready wrap stream.
module tb_demux_1x2_buf;
  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  demux_1x2_buf_if #(.WIDTH(32), .DEPTH(2)) bus ();

  demux_1x2_buf #(.WIDTH(32), .DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks run 1 unit after that.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic sel, input logic [31:0] d);
    bus.in_valid = v;
    bus.s        = sel;
    bus.I        = d;
    #1;
  endtask

  initial begin
    int exp0, exp1, nxt, cyc;
    rst_n      = 1'b0;
    bus.ready0 = 1'b0;
    bus.ready1 = 1'b0;
    drive(1'b0, 1'b0, 32'h0);
    #2;
    chk("rst_valid0", 32'(bus.valid0), 32'd0);
    chk("rst_valid1", 32'(bus.valid1), 32'd0);
    chk("rst_cnt0", 32'(bus.cnt0), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    tick();

    // Route: DEADBEEF to Y0, then 12345678 to Y1
    bus.ready0 = 1'b1; bus.ready1 = 1'b1;
    drive(1'b1, 1'b0, 32'hDEADBEEF);
    tick();
    chk("route_y0", bus.Y0, 32'hDEADBEEF);
    chk("route_v0", 32'(bus.valid0), 32'd1);
    chk("route_v1_idle", 32'(bus.valid1), 32'd0);
    drive(1'b1, 1'b1, 32'h12345678);
    tick();
    chk("route_y1", bus.Y1, 32'h12345678);
    chk("route_y0_drained", bus.Y0, 32'h0);
    drive(1'b0, 1'b0, 32'h0);
    tick();
    chk("route_v1_drained", 32'(bus.valid1), 32'd0);

    // Backpressure on Y0
    bus.ready0 = 1'b0;
    drive(1'b1, 1'b0, 32'hA); tick();
    drive(1'b1, 1'b0, 32'hB); tick();
    drive(1'b1, 1'b0, 32'hC);
    chk("bp_full_ready", 32'(bus.in_ready), 32'd0);
    tick();
    chk("bp_cnt0", 32'(bus.cnt0), 32'd2);
    chk("bp_head", bus.Y0, 32'hA);
    drive(1'b0, 1'b1, 32'hC);
    chk("bp_s1_ready", 32'(bus.in_ready), 32'd1);
    drive(1'b1, 1'b0, 32'hC);
    bus.ready0 = 1'b1;
    chk("bp_bubble", 32'(bus.in_ready), 32'd0);
    tick();
    chk("bp_y0_b", bus.Y0, 32'hB);
    chk("bp_cnt0_1", 32'(bus.cnt0), 32'd1);
    tick();
    chk("bp_y0_c", bus.Y0, 32'hC);
    drive(1'b0, 1'b0, 32'h0);
    tick();
    chk("bp_empty", 32'(bus.cnt0), 32'd0);

    // Simultaneous push and pop on FIFO 0
    bus.ready0 = 1'b0;
    drive(1'b1, 1'b0, 32'h1); tick();
    chk("pp_cnt_pre", 32'(bus.cnt0), 32'd1);
    bus.ready0 = 1'b1;
    drive(1'b1, 1'b0, 32'h2); tick();
    chk("pp_cnt", 32'(bus.cnt0), 32'd1);
    chk("pp_y0", bus.Y0, 32'h2);
    drive(1'b0, 1'b0, 32'h0); tick();

    // Full FIFO 1 refuses push despite concurrent pop
    bus.ready1 = 1'b0;
    drive(1'b1, 1'b1, 32'h3); tick();
    drive(1'b1, 1'b1, 32'h4); tick();
    chk("fb_cnt_full", 32'(bus.cnt1), 32'd2);
    bus.ready1 = 1'b1;
    drive(1'b1, 1'b1, 32'h5);
    chk("fb_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    bus.ready1 = 1'b0;
    #1;
    chk("fb_in_ready_next", 32'(bus.in_ready), 32'd1);
    tick();
    chk("fb_cnt_end", 32'(bus.cnt1), 32'd2);
    chk("fb_head", bus.Y1, 32'h4);
    drive(1'b0, 1'b0, 32'h0);
    bus.ready1 = 1'b1;
    tick();
    chk("fb_tail", bus.Y1, 32'h5);
    tick();

    // Async reset mid-stream with FIFO 0 full
    bus.ready0 = 1'b0;
    drive(1'b1, 1'b0, 32'h77); tick();
    drive(1'b1, 1'b0, 32'h88); tick();
    chk("ar_cnt0_pre", 32'(bus.cnt0), 32'd2);
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar_valid0", 32'(bus.valid0), 32'd0);
    chk("ar_valid1", 32'(bus.valid1), 32'd0);
    chk("ar_y0", bus.Y0, 32'h0);
    chk("ar_y1", bus.Y1, 32'h0);
    chk("ar_cnt0", 32'(bus.cnt0), 32'd0);
    chk("ar_cnt1", 32'(bus.cnt1), 32'd0);
    chk("ar_in_ready", 32'(bus.in_ready), 32'd1);
    drive(1'b0, 1'b0, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // Wrap stream: 0..15 alternating s, random consumer readiness
    exp0 = 0; exp1 = 1; nxt = 0; cyc = 0;
    while ((exp0 < 16 || exp1 < 17) && cyc < 400) begin
      bus.ready0 = 1'($urandom_range(0, 1));
      bus.ready1 = 1'($urandom_range(0, 1));
      if (nxt < 16) drive(1'b1, 1'(nxt & 1), 32'(nxt));
      else          drive(1'b0, 1'b0, 32'h0);
      #1;
      if (bus.valid0 && bus.ready0) begin
        chk("wrap_y0", bus.Y0, 32'(exp0));
        exp0 += 2;
      end
      if (bus.valid1 && bus.ready1) begin
        chk("wrap_y1", bus.Y1, 32'(exp1));
        exp1 += 2;
      end
      if (bus.in_valid && bus.in_ready) nxt++;
      tick();
      cyc++;
    end
    chk("wrap_done0", 32'(exp0), 32'd16);
    chk("wrap_done1", 32'(exp1), 32'd17);
    chk("wrap_cnt0", 32'(bus.cnt0), 32'd0);
    chk("wrap_cnt1", 32'(bus.cnt1), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
